line_clear_scanner: RTL

- Runs after a piece locks. Scans the playfield RAM bottom to top, detects full rows, and compacts the board in place by shifting surviving rows down and zero-filling the top.
- Reports the number of cleared rows as a one-cycle hit pulse plus a 2-bit lineCount. This is the producer side of the hit/lineCount interface consumed by the score/hit-flash logic.

---
 rtl/tetris_pkg.sv | 19 +
 rtl/line_clear_scanner_if.sv | 25 ++
 rtl/line_clear_scanner.sv | 87 ++++++++
 3 files changed

// File: rtl/tetris_pkg.sv
// tetris_pkg: board geometry, scanner FSM states and the line-count saturation helper
package tetris_pkg;
    localparam int BOARD_ROWS = 20;
    localparam int BOARD_COLS = 10;
    localparam int ROW_AW     = 5;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        READ   = 3'd1,
        EVAL   = 3'd2,
        CLEAR  = 3'd3,
        REPORT = 3'd4
    } state_e;

    // Score logic only distinguishes single/double/triple-or-better.
    function automatic logic [1:0] sat_line_count(input logic [2:0] cnt);
        return (cnt >= 3'd3) ? 2'd3 : cnt[1:0];
    endfunction
endpackage

// File: rtl/line_clear_scanner_if.sv
// line_clear_scanner_if: start/report handshake plus board RAM port of the line-clear scanner
interface line_clear_scanner_if #(
    parameter int ROW_AW = 5,
    parameter int COLS   = 10
);
    logic              start;
    logic              busy;
    logic [ROW_AW-1:0] row_addr;
    logic [COLS-1:0]   row_rdata;
    logic              row_we;
    logic [COLS-1:0]   row_wdata;
    logic              hit;
    logic [1:0]        lineCount;
    logic [2:0]        line_total;
    logic              done;

    modport master (
        input  start, row_rdata,
        output busy, row_addr, row_we, row_wdata, hit, lineCount, line_total, done
    );
    modport slave (
        output start, row_rdata,
        input  busy, row_addr, row_we, row_wdata, hit, lineCount, line_total, done
    );
endinterface

// File: rtl/line_clear_scanner.sv
// line_clear_scanner: bottom-up scan of the board RAM that drops full rows and compacts in place
module line_clear_scanner #(
    parameter int ROWS   = tetris_pkg::BOARD_ROWS,
    parameter int COLS   = tetris_pkg::BOARD_COLS,
    parameter int ROW_AW = tetris_pkg::ROW_AW
) (
    input logic                 clk,
    input logic                 rst,
    line_clear_scanner_if.master io
);
    import tetris_pkg::*;

    localparam logic [ROW_AW-1:0] LAST_ROW = ROW_AW'(ROWS - 1);

    state_e            state_q, state_d;
    logic [ROW_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [ROW_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [1:0]        line_count_q, line_count_d;
    logic [2:0]        line_total_q, line_total_d;
    logic              full;
    logic              wr_en;
    logic [2:0]        cnt_inc;

    assign full    = &io.row_rdata;
    assign cnt_inc = (cnt_q == 3'd7) ? cnt_q : cnt_q + 3'd1;

    always_comb begin
        state_d  = state_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        unique case (state_q)
            IDLE: if (io.start) begin
                rd_ptr_d = LAST_ROW;
                wr_ptr_d = LAST_ROW;
                cnt_d    = 3'd0;
                state_d  = READ;
            end
            READ: state_d = EVAL;
            EVAL: begin
                cnt_d    = full ? cnt_inc : cnt_q;
                wr_ptr_d = full ? wr_ptr_q : wr_ptr_q - 1'b1;
                rd_ptr_d = (rd_ptr_q != '0) ? rd_ptr_q - 1'b1 : rd_ptr_q;
                state_d  = (rd_ptr_q != '0) ? READ : (cnt_d != 3'd0) ? CLEAR : REPORT;
            end
            // After compaction wr_ptr sits on the lowest stale row; zero up to row 0.
            CLEAR: begin
                wr_ptr_d = wr_ptr_q - 1'b1;
                state_d  = (wr_ptr_q == '0) ? REPORT : CLEAR;
            end
            REPORT: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        line_total_d = (state_d == REPORT) ? cnt_d : line_total_q;
        line_count_d = (state_d == REPORT && cnt_d != 3'd0) ? sat_line_count(cnt_d) : line_count_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            cnt_q        <= '0;
            line_count_q <= '0;
            line_total_q <= '0;
        end else begin
            state_q      <= state_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            cnt_q        <= cnt_d;
            line_count_q <= line_count_d;
            line_total_q <= line_total_d;
        end
    end

    // Surviving rows are only rewritten when they actually move.
    assign wr_en         = (state_q == EVAL && !full && rd_ptr_q != wr_ptr_q) || state_q == CLEAR;
    assign io.busy       = state_q != IDLE;
    assign io.row_we     = wr_en;
    assign io.row_addr   = (state_q == READ) ? rd_ptr_q : wr_en ? wr_ptr_q : '0;
    assign io.row_wdata  = (state_q == EVAL && wr_en) ? io.row_rdata : '0;
    assign io.hit        = state_q == REPORT && cnt_q != 3'd0;
    assign io.done       = state_q == REPORT;
    assign io.lineCount  = line_count_q;
    assign io.line_total = line_total_q;
endmodule
